// File: rtl/codec2_sn_update.sv
// Codec2 analysis-buffer update: shifts Sn down by one frame, then appends N_SAMP new speech samples.
// Optional SN_INT_TO_Q16_EN converts loaded 16-bit integer PCM to Q16.16 before it is written.
module codec2_sn_update #(
    parameter int N       = 32,
    parameter int N_SAMP  = 80,
    parameter int M_PITCH = 320
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_sn,
    input  logic [9:0]   speech_base,
    input  logic [N-1:0] out_speech,
    input  logic [N-1:0] read_c2_sn_out,
    output logic [9:0]   addr_speech,
    output logic [9:0]   addr_sn,
    output logic [N-1:0] write_c2_sn,
    output logic         re_c2_sn,
    output logic         we_c2_sn,
    output logic         done_sn
);

    typedef enum logic [3:0] {
        START   = 4'd0,
        SH_RD   = 4'd1,
        SH_WAIT = 4'd2,
        SH_CAP  = 4'd3,
        SH_WR   = 4'd4,
        LD_RD   = 4'd5,
        LD_WAIT = 4'd6,
        LD_CAP  = 4'd7,
        LD_WR   = 4'd8,
        DONE    = 4'd9
    } state_t;

    localparam logic [9:0] SHIFT_OFS = 10'(N_SAMP);
    localparam logic [9:0] SH_LAST   = 10'(M_PITCH - N_SAMP - 1);
    localparam logic [9:0] LD_OFS    = 10'(M_PITCH - N_SAMP);
    localparam logic [9:0] LD_LAST   = 10'(N_SAMP - 1);

    state_t         state_r;
    logic [9:0]     i_r;
    logic [9:0]     base_r;
    logic [N-1:0]   sn_data_r;

    // Format of a freshly loaded speech word before it enters Sn.
    function automatic logic [N-1:0] load_value(input logic [N-1:0] raw);
`ifdef SN_INT_TO_Q16_EN
        logic [N-1:0] ext;
        ext = {{(N-16){raw[15]}}, raw[15:0]};
        return ext << 16;
`else
        return raw;
`endif
    endfunction

    // Sequencer: every output is registered from the current state and index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= START;
            i_r         <= 10'd0;
            base_r      <= 10'd0;
            sn_data_r   <= '0;
            addr_speech <= 10'd0;
            addr_sn     <= 10'd0;
            write_c2_sn <= '0;
            re_c2_sn    <= 1'b0;
            we_c2_sn    <= 1'b0;
            done_sn     <= 1'b0;
        end else begin
            re_c2_sn <= 1'b0;
            we_c2_sn <= 1'b0;
            done_sn  <= 1'b0;
            case (state_r)
                START: begin
                    if (start_sn) begin
                        state_r <= SH_RD;
                        i_r     <= 10'd0;
                        base_r  <= speech_base;
                    end else begin
                        state_r <= START;
                    end
                end
                SH_RD: begin
                    addr_sn  <= i_r + SHIFT_OFS;
                    re_c2_sn <= 1'b1;
                    state_r  <= SH_WAIT;
                end
                SH_WAIT: begin
                    addr_sn  <= i_r + SHIFT_OFS;
                    re_c2_sn <= 1'b1;
                    state_r  <= SH_CAP;
                end
                SH_CAP: begin
                    sn_data_r <= read_c2_sn_out;
                    state_r   <= SH_WR;
                end
                SH_WR: begin
                    addr_sn     <= i_r;
                    write_c2_sn <= sn_data_r;
                    we_c2_sn    <= 1'b1;
                    if (i_r == SH_LAST) begin
                        i_r     <= 10'd0;
                        state_r <= LD_RD;
                    end else begin
                        i_r     <= i_r + 10'd1;
                        state_r <= SH_RD;
                    end
                end
                LD_RD: begin
                    // 10-bit add wraps the speech address modulo 1024
                    addr_speech <= base_r + i_r;
                    state_r     <= LD_WAIT;
                end
                LD_WAIT: begin
                    addr_speech <= base_r + i_r;
                    state_r     <= LD_CAP;
                end
                LD_CAP: begin
                    sn_data_r <= load_value(out_speech);
                    state_r   <= LD_WR;
                end
                LD_WR: begin
                    addr_sn     <= LD_OFS + i_r;
                    write_c2_sn <= sn_data_r;
                    we_c2_sn    <= 1'b1;
                    if (i_r == LD_LAST) begin
                        state_r <= DONE;
                    end else begin
                        i_r     <= i_r + 10'd1;
                        state_r <= LD_RD;
                    end
                end
                DONE: begin
                    done_sn <= 1'b1;
                    state_r <= START;
                end
                default: begin
                    state_r <= START;
                end
            endcase
        end
    end

endmodule
